// File: rtl/lpm_inpad_ctrl_pkg.sv
// lpm_inpad_ctrl_pkg: shared types and helpers for the pad debounce controller.
package lpm_inpad_ctrl_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Counter width that holds 0..debounce without wrapping: ceil(log2(debounce+1))
   function automatic int cnt_width(input int debounce);
      return (debounce < 1) ? 1 : $clog2(debounce + 1);
   endfunction

endpackage

// File: rtl/lpm_inpad_sync.sv
// lpm_inpad_sync: per-bit 2-flop synchronizer for the raw pad vector.
// Honours clken so the whole controller freezes together when disabled.
module lpm_inpad_sync #(
   parameter int lpm_width = 1
) (
   input  logic                 clock,
   input  logic                 aclr,
   input  logic                 clken,
   input  logic [lpm_width-1:0] pad,
   output logic [lpm_width-1:0] sync_q
);

   genvar gi;
   generate
      for (gi = 0; gi < lpm_width; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         // Two-stage capture of one asynchronous pad bit
         always_ff @(posedge clock or posedge aclr) begin
            if (aclr) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else if (clken) begin
               meta_reg <= pad[gi];
               sync_reg <= meta_reg;
            end
         end

         assign sync_q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/lpm_inpad_ctrl.sv
// lpm_inpad_ctrl: debounces a pad vector and reports changes through a
// valid/ready event interface. A change must persist for lpm_debounce enabled
// cycles before it is accepted; while an event waits for the consumer, new pad
// activity is deferred until the event has been taken.
// Optional interrupt output: define LPM_INPAD_CTRL_IRQ_EN to add irq/irq_clr.
module lpm_inpad_ctrl
   import lpm_inpad_ctrl_pkg::*;
#(
   parameter string lpm_type     = "lpm_inpad_ctrl",
   parameter int    lpm_width    = 1,
   parameter int    lpm_debounce = 4,
   parameter string lpm_hint     = "UNUSED"
) (
   input  logic                 clock,
   input  logic                 aclr,
   input  logic                 clken,
   input  logic [lpm_width-1:0] pad,
   output logic [lpm_width-1:0] result,
   output logic [lpm_width-1:0] chg_mask,
   output logic                 chg_valid,
   input  logic                 chg_ready
`ifdef LPM_INPAD_CTRL_IRQ_EN
   ,
   input  logic                 irq_clr,
   output logic                 irq
`endif
);

   localparam int                CW       = cnt_width(lpm_debounce);
   localparam logic [CW-1:0]     CNT_LAST = CW'(lpm_debounce - 1);

   // Elaboration-time guard on the legal parameter ranges
   generate
      if (lpm_width < 1 || lpm_width > 32 || lpm_debounce < 1 || lpm_debounce > 65535
          || lpm_type == "" || lpm_hint == "") begin : g_bad_param
         $error("%s (%s): parameter out of range", lpm_type, lpm_hint);
      end
   endgenerate

   logic [lpm_width-1:0] sync_q;

   state_t               state_reg,  state_next;
   logic [lpm_width-1:0] cand_reg,   cand_next;
   logic [CW-1:0]        cnt_reg,    cnt_next;
   logic [lpm_width-1:0] result_reg, result_next;
   logic [lpm_width-1:0] mask_reg,   mask_next;
   logic                 valid_reg,  valid_next;
   logic                 event_set;

   lpm_inpad_sync #(
      .lpm_width (lpm_width)
   ) u_sync (
      .clock  (clock),
      .aclr   (aclr),
      .clken  (clken),
      .pad    (pad),
      .sync_q (sync_q)
   );

   // Next-state and datapath decisions of the debounce FSM
   always_comb begin
      state_next  = state_reg;
      cand_next   = cand_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
      mask_next   = mask_reg;
      valid_next  = valid_reg;
      event_set   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sync_q != result_reg) begin
               cand_next  = sync_q;
               cnt_next   = '0;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (sync_q == result_reg) begin
               // Glitch vanished before it was accepted
               state_next = IDLE;
            end else if (sync_q != cand_reg) begin
               // Pad moved again: restart the stability window on the new value
               cand_next = sync_q;
               cnt_next  = '0;
            end else if (cnt_reg == CNT_LAST) begin
               result_next = cand_reg;
               mask_next   = cand_reg ^ result_reg;
               valid_next  = 1'b1;
               event_set   = 1'b1;
               state_next  = REPORT;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         REPORT: begin
            // Pad is ignored here; IDLE re-evaluates it after the handshake
            if (chg_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM and datapath registers, frozen while clken is low
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state_reg  <= IDLE;
         cand_reg   <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         mask_reg   <= '0;
         valid_reg  <= 1'b0;
      end else if (clken) begin
         state_reg  <= state_next;
         cand_reg   <= cand_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         mask_reg   <= mask_next;
         valid_reg  <= valid_next;
      end
   end

   assign result    = result_reg;
   assign chg_mask  = mask_reg;
   assign chg_valid = valid_reg;

`ifdef LPM_INPAD_CTRL_IRQ_EN
   logic irq_reg;

   // Sticky interrupt: set on each accepted event, set beats a coincident clear
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         irq_reg <= 1'b0;
      end else if (clken) begin
         if (event_set) begin
            irq_reg <= 1'b1;
         end else if (irq_clr) begin
            irq_reg <= 1'b0;
         end
      end
   end

   assign irq = irq_reg;
`else
   logic unused_event;
   assign unused_event = event_set;
`endif

endmodule

// File: tb/tb_lpm_inpad_ctrl.sv
// tb_lpm_inpad_ctrl: directed self-checking bench for lpm_inpad_ctrl
// (lpm_width=4, lpm_debounce=3, so a clean step is accepted 6 enabled cycles later).
// Covers the irq path too when LPM_INPAD_CTRL_IRQ_EN is defined.
module tb_lpm_inpad_ctrl;

   localparam int W  = 4;
   localparam int DB = 3;

   logic         clock = 1'b0;
   logic         aclr;
   logic         clken;
   logic [W-1:0] pad;
   logic [W-1:0] result;
   logic [W-1:0] chg_mask;
   logic         chg_valid;
   logic         chg_ready;
`ifdef LPM_INPAD_CTRL_IRQ_EN
   logic         irq_clr;
   logic         irq;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic seen;

   always #5 clock = ~clock;

   lpm_inpad_ctrl #(
      .lpm_width    (W),
      .lpm_debounce (DB)
   ) dut (
      .clock     (clock),
      .aclr      (aclr),
      .clken     (clken),
      .pad       (pad),
      .result    (result),
      .chg_mask  (chg_mask),
      .chg_valid (chg_valid),
      .chg_ready (chg_ready)
`ifdef LPM_INPAD_CTRL_IRQ_EN
      ,
      .irq_clr   (irq_clr),
      .irq       (irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Advance n edges and report whether chg_valid was ever seen high
   task automatic tick_watch(input int n, output logic any_valid);
      any_valid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
         any_valid = any_valid | chg_valid;
      end
   endtask

   task automatic do_reset();
      aclr = 1'b1;
      tick(1);
      aclr = 1'b0;
      tick(1);
   endtask

   task automatic handshake(input string tag);
      chg_ready = 1'b1;
      tick(1);
      chg_ready = 1'b0;
      check({tag, "_hs_valid"}, {31'd0, chg_valid}, 32'd0);
   endtask

   initial begin
      aclr      = 1'b1;
      clken     = 1'b1;
      chg_ready = 1'b0;
      pad       = 4'b0000;
`ifdef LPM_INPAD_CTRL_IRQ_EN
      irq_clr   = 1'b0;
`endif
      tick(2);
      check("rst_result", {28'd0, result}, 32'h0);
      check("rst_mask",   {28'd0, chg_mask}, 32'h0);
      check("rst_valid",  {31'd0, chg_valid}, 32'h0);
      check("rst_state",  {30'd0, dut.state_reg}, 32'h0);
`ifdef LPM_INPAD_CTRL_IRQ_EN
      check("rst_irq",    {31'd0, irq}, 32'h0);
`endif
      aclr = 1'b0;
      tick(2);

      // Clean step 0000->0101: event exactly 6 cycles later, holds until ready
      pad = 4'b0101;
      tick(5);
      check("s1_valid_at5",  {31'd0, chg_valid}, 32'h0);
      check("s1_result_at5", {28'd0, result}, 32'h0);
      tick(1);
      check("s1_result_at6", {28'd0, result}, 32'h5);
      check("s1_mask_at6",   {28'd0, chg_mask}, 32'h5);
      check("s1_valid_at6",  {31'd0, chg_valid}, 32'h1);
      tick(3);
      check("s1_hold_valid", {31'd0, chg_valid}, 32'h1);
      check("s1_hold_mask",  {28'd0, chg_mask}, 32'h5);
      handshake("s1");
      check("s1_post_result", {28'd0, result}, 32'h5);

      // chg_ready with nothing pending is a no-op
      chg_ready = 1'b1;
      tick(3);
      chg_ready = 1'b0;
      check("idle_ready_valid",  {31'd0, chg_valid}, 32'h0);
      check("idle_ready_result", {28'd0, result}, 32'h5);

      // Two-cycle glitch is rejected
      pad = 4'b0000;
      do_reset();
      tick(2);
      pad = 4'b0001;
      tick(2);
      pad = 4'b0000;
      tick_watch(10, seen);
      check("s2_no_event",  {31'd0, seen}, 32'h0);
      check("s2_result",    {28'd0, result}, 32'h0);

      // 0001 then 0011: window restarts on 0011, single event
      pad = 4'b0001;
      tick(1);
      pad = 4'b0011;
      tick_watch(5, seen);
      check("s3_no_early", {31'd0, seen}, 32'h0);
      tick(1);
      check("s3_valid",  {31'd0, chg_valid}, 32'h1);
      check("s3_result", {28'd0, result}, 32'h3);
      check("s3_mask",   {28'd0, chg_mask}, 32'h3);

      // Pad moves to 1000 while the event is stalled: deferred, not lost
      pad = 4'b1000;
      tick(10);
      check("s4_hold_valid",  {31'd0, chg_valid}, 32'h1);
      check("s4_hold_result", {28'd0, result}, 32'h3);
      check("s4_hold_mask",   {28'd0, chg_mask}, 32'h3);
      handshake("s4a");
      tick(3);
      check("s4_valid_early", {31'd0, chg_valid}, 32'h0);
      check("s4_result_early", {28'd0, result}, 32'h3);
      tick(1);
      check("s4_valid2",  {31'd0, chg_valid}, 32'h1);
      check("s4_result2", {28'd0, result}, 32'h8);
      check("s4_mask2",   {28'd0, chg_mask}, 32'hB);
      handshake("s4b");

      // aclr mid-SETTLE: immediate clear, then restart against result=0
      pad = 4'b1001;
      tick(4);
      aclr = 1'b1;
      #1;
      check("s5_rst_result", {28'd0, result}, 32'h0);
      check("s5_rst_mask",   {28'd0, chg_mask}, 32'h0);
      check("s5_rst_valid",  {31'd0, chg_valid}, 32'h0);
      check("s5_rst_state",  {30'd0, dut.state_reg}, 32'h0);
      tick(1);
      aclr = 1'b0;
      tick(5);
      check("s5_valid_at5", {31'd0, chg_valid}, 32'h0);
      tick(1);
      check("s5_valid_at6", {31'd0, chg_valid}, 32'h1);
      check("s5_result",    {28'd0, result}, 32'h9);
      check("s5_mask",      {28'd0, chg_mask}, 32'h9);
      handshake("s5a");

      // clken low for 5 cycles mid-SETTLE stretches latency by 5
      pad = 4'b0110;
      tick(4);
      clken = 1'b0;
      tick(5);
      check("s6_frozen_valid",  {31'd0, chg_valid}, 32'h0);
      check("s6_frozen_result", {28'd0, result}, 32'h9);
      clken = 1'b1;
      tick(1);
      check("s6_valid_at10", {31'd0, chg_valid}, 32'h0);
      tick(1);
      check("s6_valid_at11", {31'd0, chg_valid}, 32'h1);
      check("s6_result",     {28'd0, result}, 32'h6);
      check("s6_mask",       {28'd0, chg_mask}, 32'hF);
      handshake("s6");

`ifdef LPM_INPAD_CTRL_IRQ_EN
      // Sticky irq from earlier events, clear, then set-beats-clear
      check("irq_sticky", {31'd0, irq}, 32'h1);
      irq_clr = 1'b1;
      tick(1);
      check("irq_cleared", {31'd0, irq}, 32'h0);
      pad = 4'b0000;
      tick(5);
      check("irq_before_evt", {31'd0, irq}, 32'h0);
      tick(1);
      check("irq_set_wins", {31'd0, irq}, 32'h1);
      check("irq_evt_valid", {31'd0, chg_valid}, 32'h1);
      check("irq_evt_mask",  {28'd0, chg_mask}, 32'h6);
      tick(1);
      check("irq_clr_next", {31'd0, irq}, 32'h0);
      irq_clr = 1'b0;
      handshake("irq");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
